baud_rate_ctrl: RTL and testbench

- Owns the UART baud timing: holds the active divisor, generates the oversample tick (s_tick) and the bit tick (tx_tick, one per OVS s_ticks).
- Arbitrates runtime divisor reconfiguration against traffic. A new divisor is accepted through a valid/ready handshake and applied only when both transmitter and receiver are idle, so no frame is corrupted.
- Sits between the host config interface and the uart_tx/uart_rx cores.

---
 rtl/baud_pkg.sv | 40 ++++
 rtl/baud_rate_ctrl_if.sv | 36 +++
 rtl/tick_divider.sv | 45 ++++
 rtl/baud_rate_ctrl.sv | 148 ++++++++++++++
 tb/tb_baud_rate_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/baud_pkg.sv
// -----------------------------------------------------------------------------
// baud_pkg
// Shared definitions for the UART baud-timing block:
//   - controller state encoding (RUN / WAIT / APPLY)
//   - default divisor width, reset divisor and oversample ratio
//   - divisor values for the standard rates at a 100 MHz system clock
//   - a helper that computes a divisor for an arbitrary rate
// A divisor value D gives one oversample tick every D+1 clock cycles.
// -----------------------------------------------------------------------------
package baud_pkg;

  // Controller states; values are fixed so that waveforms and older
  // register dumps decode identically.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_APPLY = 2'd2
  } baud_state_e;

  localparam int BAUD_DIV_W       = 10;
  localparam int BAUD_OVS         = 16;
  localparam int BAUD_SYS_CLK_HZ  = 100_000_000;

  // Divisors for 16x oversampling at 100 MHz (period = divisor + 1 cycles).
  localparam int BAUD_DIV_9600    = 650;
  localparam int BAUD_DIV_19200   = 325;
  localparam int BAUD_DIV_115200  = 53;
  localparam int BAUD_DEFAULT_DIV = BAUD_DIV_9600;

  // Nearest divisor for a given clock, oversample ratio and baud rate.
  // The tick period is round(clk / (ovs * baud)) cycles, divisor is one less.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned ovs,
                                           input int unsigned baud);
    int unsigned step;
    step = ovs * baud;
    return ((clk_hz + (step / 32'd2)) / step) - 32'd1;
  endfunction

endpackage : baud_pkg

// File: rtl/baud_rate_ctrl_if.sv
// -----------------------------------------------------------------------------
// baud_rate_ctrl_if
// Bundles the configuration handshake, traffic status and tick outputs of the
// baud-rate controller.
//   master : host/core side - drives enable, cfg_valid, cfg_div, tx_busy,
//            rx_busy; observes cfg_ready, s_tick, tx_tick, cur_div, pending.
//   slave  : the controller itself (opposite directions).
// -----------------------------------------------------------------------------
interface baud_rate_ctrl_if
  import baud_pkg::*;
#(
  parameter int DIV_W = BAUD_DIV_W
);

  logic             enable;     // tick generation enable
  logic             cfg_valid;  // new divisor offered
  logic [DIV_W-1:0] cfg_div;    // offered divisor
  logic             cfg_ready;  // controller can accept cfg_div
  logic             tx_busy;    // transmitter mid-frame
  logic             rx_busy;    // receiver mid-frame
  logic             s_tick;     // oversample tick
  logic             tx_tick;    // bit tick
  logic [DIV_W-1:0] cur_div;    // divisor in effect
  logic             pending;    // accepted divisor awaiting application

  modport master (
    output enable, cfg_valid, cfg_div, tx_busy, rx_busy,
    input  cfg_ready, s_tick, tx_tick, cur_div, pending
  );

  modport slave (
    input  enable, cfg_valid, cfg_div, tx_busy, rx_busy,
    output cfg_ready, s_tick, tx_tick, cur_div, pending
  );

endinterface : baud_rate_ctrl_if

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Free-running cycle counter that pulses 'tick' when the count reaches 'div'
// and then wraps to zero, giving a period of div+1 cycles (div=0 -> tick
// every cycle).
// Ports:
//   clk    in  system clock, rising edge
//   clear  in  synchronous active-high reset
//   enable in  count enable; while low the count is held at zero
//   reload in  restart request; count forced to zero, tick suppressed
//   div    in  terminal count
//   tick   out one-cycle pulse on terminal count
// -----------------------------------------------------------------------------
module tick_divider
  import baud_pkg::*;
#(
  parameter int DIV_W = BAUD_DIV_W
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic             reload,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_r;
  logic             tick_s;

  // The terminal-count compare is gated so a reload cycle never emits a tick.
  assign tick_s = enable && !reload && (cnt_r == div);
  assign tick   = tick_s;

  // Counter: hold at zero when disabled or reloading, wrap on terminal count.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (!enable || reload || tick_s) begin
      cnt_r <= {DIV_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + DIV_W'(1);
    end
  end

endmodule : tick_divider

// File: rtl/baud_rate_ctrl.sv
// -----------------------------------------------------------------------------
// baud_rate_ctrl
// Owns UART baud timing: holds the active divisor, produces the oversample
// tick (s_tick, every cur_div+1 cycles) and the bit tick (tx_tick, one per
// OVS s_ticks), and safely swaps in a new divisor between frames.
// A divisor is accepted over a valid/ready handshake into a shadow register
// and copied to cur_div only in a one-cycle APPLY state entered when both
// tx and rx cores are idle (or ticks are disabled). APPLY restarts both
// counters so the first tick at the new rate is clean.
// Ports:
//   clk   in  system clock, rising edge
//   clear in  synchronous active-high reset
//   bus   slave side of baud_rate_ctrl_if (handshake, busy inputs, ticks,
//         cur_div, pending)
// -----------------------------------------------------------------------------
module baud_rate_ctrl
  import baud_pkg::*;
#(
  parameter int DIV_W       = BAUD_DIV_W,
  parameter int DEFAULT_DIV = BAUD_DEFAULT_DIV,
  parameter int OVS         = BAUD_OVS
) (
  input  logic             clk,
  input  logic             clear,
  baud_rate_ctrl_if.slave  bus
);

  localparam int               OCNT_W   = $clog2(OVS);
  localparam logic [OCNT_W-1:0] OCNT_MAX = OCNT_W'(OVS - 1);
  localparam logic [DIV_W-1:0]  DIV_RST  = DIV_W'(DEFAULT_DIV);

  baud_state_e       state_r;
  baud_state_e       state_nxt_s;
  logic [DIV_W-1:0]  cur_div_r;
  logic [DIV_W-1:0]  shadow_r;
  logic [OCNT_W-1:0] ocnt_r;
  logic              apply_s;
  logic              accept_s;
  logic              idle_s;
  logic              s_tick_s;
  logic              tx_tick_s;

  assign apply_s  = (state_r == ST_APPLY);
  assign accept_s = bus.cfg_valid && (state_r == ST_RUN);
  // With ticks disabled no frame can be in flight at a meaningful rate, so
  // the swap need not wait for the busy flags.
  assign idle_s   = (!bus.tx_busy && !bus.rx_busy) || !bus.enable;

  // Next-state logic for the reconfiguration FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        // Busy is sampled at acceptance too, so an idle link skips WAIT.
        if (accept_s) begin
          if (idle_s) begin
            state_nxt_s = ST_APPLY;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (idle_s) begin
          state_nxt_s = ST_APPLY;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_APPLY: begin
        state_nxt_s = ST_RUN;
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Shadow divisor captured on handshake; reset discards any waiting value.
  always_ff @(posedge clk) begin
    if (clear) begin
      shadow_r <= {DIV_W{1'b0}};
    end else if (accept_s) begin
      shadow_r <= bus.cfg_div;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Active divisor, updated only in the APPLY cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      cur_div_r <= DIV_RST;
    end else if (apply_s) begin
      cur_div_r <= shadow_r;
    end else begin
      cur_div_r <= cur_div_r;
    end
  end

  tick_divider #(
    .DIV_W (DIV_W)
  ) u_tick_divider (
    .clk    (clk),
    .clear  (clear),
    .enable (bus.enable),
    .reload (apply_s),
    .div    (cur_div_r),
    .tick   (s_tick_s)
  );

  // Oversample counter: counts s_ticks, restarted by APPLY and held when off.
  always_ff @(posedge clk) begin
    if (clear) begin
      ocnt_r <= {OCNT_W{1'b0}};
    end else if (apply_s || !bus.enable) begin
      ocnt_r <= {OCNT_W{1'b0}};
    end else if (s_tick_s) begin
      if (ocnt_r == OCNT_MAX) begin
        ocnt_r <= {OCNT_W{1'b0}};
      end else begin
        ocnt_r <= ocnt_r + OCNT_W'(1);
      end
    end else begin
      ocnt_r <= ocnt_r;
    end
  end

  assign tx_tick_s = s_tick_s && (ocnt_r == OCNT_MAX);

  assign bus.s_tick    = s_tick_s;
  assign bus.tx_tick   = tx_tick_s;
  assign bus.cur_div   = cur_div_r;
  assign bus.cfg_ready = (state_r == ST_RUN);
  assign bus.pending   = (state_r != ST_RUN);

endmodule : baud_rate_ctrl

// File: tb/tb_baud_rate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_baud_rate_ctrl
// Directed self-checking bench for baud_rate_ctrl with DEFAULT_DIV=4, OVS=4.
// Cycle k is the clock period that starts k rising edges after the last reset
// edge; inputs are changed and outputs sampled just after the falling edge.
// -----------------------------------------------------------------------------
module tb_baud_rate_ctrl;

  localparam int DIV_W   = 10;
  localparam int DEF_DIV = 4;
  localparam int OVS_P   = 4;

  logic clk = 1'b0;
  logic clear;
  int   cyc;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  baud_rate_ctrl_if #(.DIV_W(DIV_W)) bif ();

  baud_rate_ctrl #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEF_DIV),
    .OVS         (OVS_P)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bif)
  );

  // Cycle index relative to the most recent reset edge.
  always @(posedge clk) begin
    if (clear) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Advance to the falling edge of cycle n (bounded).
  task automatic wait_to(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cyc !== n) begin
      errors++;
      $display("FAIL wait_to: cycle %0d, wanted %0d", cyc, n);
    end
  endtask

  // Compare {s_tick, tx_tick, cfg_ready, pending} and cur_div for one cycle.
  task automatic test_reset();
    logic [3:0] exp_v;
    clear = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    #1;
    checks++;
    if (bif.cur_div !== 10'd4) begin
      errors++;
      $display("FAIL reset_cur_div: got %0d exp %0d", bif.cur_div, 4);
    end
    for (int c = 0; c < 20; c++) begin
      wait_to(c);
      #1;
      exp_v = {(c % 5) == 4, c == 19, 1'b1, 1'b0};
      checks++;
      if ({bif.s_tick, bif.tx_tick, bif.cfg_ready, bif.pending} !== exp_v) begin
        errors++;
        $display("FAIL reset_ticks c=%0d: got %b exp %b", c,
                 {bif.s_tick, bif.tx_tick, bif.cfg_ready, bif.pending}, exp_v);
      end
    end
  endtask

  task automatic test_fast_apply();
    logic [3:0]       exp_v;
    logic [DIV_W-1:0] exp_d;
    logic             es;
    for (int c = 30; c <= 46; c++) begin
      wait_to(c);
      bif.cfg_valid = (c == 33);
      bif.cfg_div   = 10'd2;
      #1;
      es = (c < 34) ? ((c % 5) == 4) : ((c >= 37) && ((c - 37) % 3 == 0));
      exp_v = {es, c == 46, c != 34, c == 34};
      exp_d = (c <= 34) ? 10'd4 : 10'd2;
      checks++;
      if ({bif.s_tick, bif.tx_tick, bif.cfg_ready, bif.pending} !== exp_v) begin
        errors++;
        $display("FAIL fast_apply c=%0d: got %b exp %b", c,
                 {bif.s_tick, bif.tx_tick, bif.cfg_ready, bif.pending}, exp_v);
      end
      checks++;
      if (bif.cur_div !== exp_d) begin
        errors++;
        $display("FAIL fast_apply_div c=%0d: got %0d exp %0d", c, bif.cur_div, exp_d);
      end
    end
  endtask

  task automatic test_wait_busy();
    logic [3:0]       exp_v;
    logic [DIV_W-1:0] exp_d;
    logic             es;
    logic             ep;
    for (int c = 50; c <= 88; c++) begin
      wait_to(c);
      bif.cfg_valid = (c == 50);
      bif.cfg_div   = 10'd7;
      bif.tx_busy   = (c < 70);
      #1;
      if (c <= 70)      es = (c >= 52) && ((c - 52) % 3 == 0);
      else if (c == 71) es = 1'b0;
      else              es = (c == 79) || (c == 87);
      ep = (c >= 51) && (c <= 71);
      exp_v = {es, (c == 58) || (c == 70), !ep, ep};
      exp_d = (c <= 71) ? 10'd2 : 10'd7;
      checks++;
      if ({bif.s_tick, bif.tx_tick, bif.cfg_ready, bif.pending} !== exp_v) begin
        errors++;
        $display("FAIL wait_busy c=%0d: got %b exp %b", c,
                 {bif.s_tick, bif.tx_tick, bif.cfg_ready, bif.pending}, exp_v);
      end
      checks++;
      if (bif.cur_div !== exp_d) begin
        errors++;
        $display("FAIL wait_busy_div c=%0d: got %0d exp %0d", c, bif.cur_div, exp_d);
      end
    end
    bif.tx_busy = 1'b0;
  endtask

  task automatic test_held_offer();
    logic [3:0]       exp_v;
    logic [DIV_W-1:0] exp_d;
    logic             er;
    for (int c = 90; c <= 101; c++) begin
      wait_to(c);
      bif.rx_busy   = (c < 96);
      bif.cfg_valid = (c <= 98);
      bif.cfg_div   = (c == 90) ? 10'd5 : 10'd3;
      #1;
      er = (c == 90) || (c == 98) || (c >= 100);
      exp_v = {c == 95, 1'b0, er, !er};
      exp_d = (c <= 97) ? 10'd7 : ((c <= 99) ? 10'd5 : 10'd3);
      checks++;
      if ({bif.s_tick, bif.tx_tick, bif.cfg_ready, bif.pending} !== exp_v) begin
        errors++;
        $display("FAIL held_offer c=%0d: got %b exp %b", c,
                 {bif.s_tick, bif.tx_tick, bif.cfg_ready, bif.pending}, exp_v);
      end
      checks++;
      if (bif.cur_div !== exp_d) begin
        errors++;
        $display("FAIL held_offer_div c=%0d: got %0d exp %0d", c, bif.cur_div, exp_d);
      end
    end
    bif.cfg_valid = 1'b0;
  endtask

  task automatic test_disable();
    logic [3:0]       exp_v;
    logic [DIV_W-1:0] exp_d;
    logic             es;
    logic             ep;
    for (int c = 103; c <= 134; c++) begin
      wait_to(c);
      bif.rx_busy   = (c >= 110) && (c < 120);
      bif.cfg_valid = (c == 110);
      bif.cfg_div   = 10'd6;
      bif.enable    = !((c >= 111) && (c < 120));
      #1;
      if (c <= 110)     es = (c == 103) || (c == 107);
      else if (c < 120) es = 1'b0;
      else              es = (c == 126) || (c == 133);
      ep = (c == 111) || (c == 112);
      exp_v = {es, 1'b0, !ep, ep};
      exp_d = (c <= 112) ? 10'd3 : 10'd6;
      checks++;
      if ({bif.s_tick, bif.tx_tick, bif.cfg_ready, bif.pending} !== exp_v) begin
        errors++;
        $display("FAIL disable c=%0d: got %b exp %b", c,
                 {bif.s_tick, bif.tx_tick, bif.cfg_ready, bif.pending}, exp_v);
      end
      checks++;
      if (bif.cur_div !== exp_d) begin
        errors++;
        $display("FAIL disable_div c=%0d: got %0d exp %0d", c, bif.cur_div, exp_d);
      end
    end
  endtask

  task automatic test_clear_in_wait();
    logic [3:0]       exp_v;
    logic [DIV_W-1:0] exp_d;
    wait_to(140);
    bif.tx_busy   = 1'b1;
    bif.cfg_valid = 1'b1;
    bif.cfg_div   = 10'd9;
    wait_to(141);
    bif.cfg_valid = 1'b0;
    #1;
    checks++;
    if (bif.pending !== 1'b1) begin
      errors++;
      $display("FAIL clear_pre_pending: got %b exp 1", bif.pending);
    end
    wait_to(143);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    bif.tx_busy = 1'b0;
    #1;
    checks++;
    if ({bif.cur_div, bif.cfg_ready, bif.pending} !== {10'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL clear_state: got div=%0d rdy=%b pend=%b exp div=4 rdy=1 pend=0",
               bif.cur_div, bif.cfg_ready, bif.pending);
    end
    for (int c = 0; c <= 14; c++) begin
      wait_to(c);
      bif.cfg_valid = (c == 2);
      bif.cfg_div   = 10'd0;
      #1;
      exp_v = {c >= 4, (c >= 4) && ((c - 4) % 4 == 3), c != 3, c == 3};
      exp_d = (c <= 3) ? 10'd4 : 10'd0;
      checks++;
      if ({bif.s_tick, bif.tx_tick, bif.cfg_ready, bif.pending} !== exp_v) begin
        errors++;
        $display("FAIL div_zero c=%0d: got %b exp %b", c,
                 {bif.s_tick, bif.tx_tick, bif.cfg_ready, bif.pending}, exp_v);
      end
      checks++;
      if (bif.cur_div !== exp_d) begin
        errors++;
        $display("FAIL div_zero_div c=%0d: got %0d exp %0d", c, bif.cur_div, exp_d);
      end
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    clear         = 1'b1;
    bif.enable    = 1'b1;
    bif.cfg_valid = 1'b0;
    bif.cfg_div   = 10'd0;
    bif.tx_busy   = 1'b0;
    bif.rx_busy   = 1'b0;
    test_reset();
    test_fast_apply();
    test_wait_busy();
    test_held_offer();
    test_disable();
    test_clear_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_baud_rate_ctrl
